// File: rtl/inst_mem_burst_slave_pkg.sv
// Shared constants and types for the instruction-memory burst slave.
package inst_mem_burst_slave_pkg;

    localparam int unsigned INST_BITS       = 32;
    localparam int unsigned INST_ADDR_BITS  = 18;
    localparam int unsigned INST_BURST_BITS = 4;

    // Burst engine state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } eng_state_e;

endpackage

// File: rtl/inst_mem_burst_slave_if.sv
// Avalon-MM style burst-read command/response bus.
interface inst_mem_burst_slave_if
    import inst_mem_burst_slave_pkg::*;
#(
    parameter int unsigned p_addr_bits  = INST_ADDR_BITS,
    parameter int unsigned p_data_bits  = INST_BITS,
    parameter int unsigned p_burst_bits = INST_BURST_BITS
) ();

    logic                    i_read;
    logic [p_addr_bits-1:0]  i_addr;
    logic [p_burst_bits-1:0] i_burstcount;
    logic                    o_waitrequest;
    logic [p_data_bits-1:0]  o_readdata;
    logic                    o_readdatavalid;

    modport master (
        output i_read, i_addr, i_burstcount,
        input  o_waitrequest, o_readdata, o_readdatavalid
    );

    modport slave (
        input  i_read, i_addr, i_burstcount,
        output o_waitrequest, o_readdata, o_readdatavalid
    );

endinterface

// File: rtl/inst_mem_burst_slave_fifo.sv
// Small first-word-fall-through FIFO holding pending read commands.
module inst_mem_burst_slave_fifo #(
    parameter int unsigned p_width      = 22,
    parameter int unsigned p_depth      = 4,
    parameter int unsigned p_depth_log2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [p_width-1:0]      data_i,
    input  logic                    pop_i,
    output logic [p_width-1:0]      head_o,
    output logic                    empty_o,
    output logic [p_depth_log2:0]   count_o
);

    localparam int unsigned CNT_BITS = p_depth_log2 + 1;

    logic [p_width-1:0]      store_q [p_depth];
    logic [p_depth_log2-1:0] wr_ptr_q;
    logic [p_depth_log2-1:0] rd_ptr_q;
    logic [CNT_BITS-1:0]     count_q;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + p_depth_log2'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + p_depth_log2'(1);
            end
            count_q <= count_q + CNT_BITS'(push_i) - CNT_BITS'(pop_i);
        end
    end

    assign head_o  = store_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/inst_mem_burst_slave.sv
// Burst-read instruction memory: queues read commands and streams words back in order.
module inst_mem_burst_slave
    import inst_mem_burst_slave_pkg::*;
#(
    parameter int unsigned p_addr_bits      = INST_ADDR_BITS,
    parameter int unsigned p_data_bits      = INST_BITS,
    parameter int unsigned p_mem_depth_log2 = 10,
    parameter int unsigned p_burst_bits     = INST_BURST_BITS,
    parameter int unsigned p_cmd_depth      = 4,
    parameter int unsigned p_cmd_depth_log2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_mem_burst_slave_if.slave   bus,
    input  logic                    i_load_we,
    input  logic [p_addr_bits-1:0]  i_load_addr,
    input  logic [p_data_bits-1:0]  i_load_data,
    output logic                    o_busy
);

    localparam int unsigned CMD_BITS  = p_addr_bits + p_burst_bits;
    localparam int unsigned MEM_DEPTH = 1 << p_mem_depth_log2;
    localparam int unsigned CNT_BITS  = p_cmd_depth_log2 + 1;
    localparam int unsigned MA_BITS   = p_mem_depth_log2;

    logic [p_data_bits-1:0]  mem_q [MEM_DEPTH];

    eng_state_e              state_q, state_d;
    logic [MA_BITS-1:0]      addr_q, addr_d;
    logic [p_burst_bits-1:0] beats_q, beats_d;
    logic                    valid_q, valid_d;
    logic [p_data_bits-1:0]  data_q, data_d;
    logic                    wait_q, wait_d;
    logic                    busy_q, busy_d;

    logic                    push_c;
    logic                    pop_c;
    logic [CMD_BITS-1:0]     head_c;
    logic                    empty_c;
    logic [CNT_BITS-1:0]     count_c;
    logic [CNT_BITS-1:0]     count_nxt_c;
    logic [p_addr_bits-1:0]  cmd_addr_c;
    logic [p_burst_bits-1:0] cmd_bc_c;
    logic [p_burst_bits-1:0] cmd_beats_c;
    logic                    unused_addr_bits;

    assign push_c = bus.i_read && !wait_q;

    inst_mem_burst_slave_fifo #(
        .p_width      (CMD_BITS),
        .p_depth      (p_cmd_depth),
        .p_depth_log2 (p_cmd_depth_log2)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .data_i  ({bus.i_addr, bus.i_burstcount}),
        .pop_i   (pop_c),
        .head_o  (head_c),
        .empty_o (empty_c),
        .count_o (count_c)
    );

    // Unpack head command; a zero burstcount still returns one beat
    assign cmd_addr_c  = head_c[CMD_BITS-1:p_burst_bits];
    assign cmd_bc_c    = head_c[p_burst_bits-1:0];
    assign cmd_beats_c = (cmd_bc_c == '0) ? p_burst_bits'(1) : cmd_bc_c;
    assign count_nxt_c = count_c + CNT_BITS'(push_c) - CNT_BITS'(pop_c);

    // Only the low address bits select a word; the rest alias modulo depth
    assign unused_addr_bits = &{1'b0, cmd_addr_c[p_addr_bits-1:MA_BITS],
                                i_load_addr[p_addr_bits-1:MA_BITS]};

    // Load port write; the burst read below samples the pre-write word
    always_ff @(posedge clk) begin
        if (i_load_we) begin
            mem_q[i_load_addr[MA_BITS-1:0]] <= i_load_data;
        end
    end

    // Burst engine next-state, memory read and output staging
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        pop_c   = 1'b0;
        valid_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    addr_d  = cmd_addr_c[MA_BITS-1:0];
                    beats_d = cmd_beats_c;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                valid_d = 1'b1;
                data_d  = mem_q[addr_q];
                addr_d  = addr_q + MA_BITS'(1);
                beats_d = beats_q - p_burst_bits'(1);
                if (beats_q == p_burst_bits'(1)) begin
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        addr_d  = cmd_addr_c[MA_BITS-1:0];
                        beats_d = cmd_beats_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wait_d = (count_nxt_c == CNT_BITS'(p_cmd_depth));
        busy_d = (state_d == ST_BURST) || (count_nxt_c != '0) || valid_d;
    end

    // Engine and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            wait_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_waitrequest   = wait_q;
    assign bus.o_readdata      = data_q;
    assign bus.o_readdatavalid = valid_q;
    assign o_busy              = busy_q;

endmodule

// File: tb/tb_inst_mem_burst_slave.sv
// Self-checking bench for inst_mem_burst_slave with a cycle-schedule reference model.
module tb_inst_mem_burst_slave;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk;
    logic          rst;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          busy;

    inst_mem_burst_slave_if #(.p_addr_bits(AW), .p_data_bits(DW), .p_burst_bits(BW)) bus ();

    inst_mem_burst_slave dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .i_load_we   (load_we),
        .i_load_addr (load_addr),
        .i_load_data (load_data),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: schedules each accepted command's beats onto absolute edges
    typedef struct {
        int e;
        int a;
    } beat_t;

    logic [DW-1:0] mem_m [1024];
    int            cyc = 0;
    int            pops_q[$];
    beat_t         beats_q[$];
    int            free_pop = 0;
    logic          m_wait = 1'b1;
    logic          m_valid = 1'b0;
    logic          m_busy = 1'b0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_busy  = 1'b0;
            pops_q.delete();
            beats_q.delete();
            free_pop = 0;
        end else begin
            cyc++;
            m_valid = 1'b0;
            if (beats_q.size() > 0 && beats_q[0].e == cyc) begin
                m_valid = 1'b1;
                m_data  = mem_m[beats_q[0].a];
                void'(beats_q.pop_front());
            end
            if (load_we) mem_m[load_addr % 1024] = load_data;
            if (bus.i_read && !m_wait) begin
                int p;
                int n;
                p = (cyc + 1 > free_pop) ? cyc + 1 : free_pop;
                n = (bus.i_burstcount == 0) ? 1 : int'(bus.i_burstcount);
                pops_q.push_back(p);
                for (int i = 0; i < n; i++) begin
                    beat_t b;
                    b.e = p + 1 + i;
                    b.a = (int'(bus.i_addr) + i) % 1024;
                    beats_q.push_back(b);
                end
                free_pop = p + n;
            end
            while (pops_q.size() > 0 && pops_q[0] <= cyc) void'(pops_q.pop_front());
            m_wait = (pops_q.size() == 4);
            m_busy = m_valid || (beats_q.size() > 0);
        end
    end

    // Per-cycle comparison and beat capture
    logic [DW-1:0] got_d[$];
    int            got_c[$];
    logic          saw_wait = 1'b0;

    always @(negedge clk) begin
        chk("waitrequest", 32'(bus.o_waitrequest), 32'(m_wait));
        chk("readdatavalid", 32'(bus.o_readdatavalid), 32'(m_valid));
        chk("readdata", bus.o_readdata, m_data);
        chk("busy", 32'(busy), 32'(m_busy));
        if (rst && bus.o_waitrequest) saw_wait = 1'b1;
        if (bus.o_readdatavalid) begin
            got_d.push_back(bus.o_readdata);
            got_c.push_back(cyc);
        end
    end

    // Present a command at a negedge and hold it until accepted
    task automatic issue(input int a, input int bc, output int acc);
        logic wr;
        acc = -1;
        bus.i_read       = 1'b1;
        bus.i_addr       = AW'(a);
        bus.i_burstcount = BW'(bc);
        for (int k = 0; k < 200; k++) begin
            wr = bus.o_waitrequest;
            @(negedge clk);
            if (!wr) begin
                acc = cyc;
                return;
            end
        end
        chk("issue_timeout", 32'(1), 32'(0));
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        load_we   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        @(negedge clk);
        load_we   = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && !bus.o_readdatavalid) return;
        end
        chk("drain_timeout", 32'(busy), 32'(0));
    endtask

    task automatic clear_got();
        got_d.delete();
        got_c.delete();
    endtask

    int t;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        load_we          = 1'b0;
        load_addr        = '0;
        load_data        = '0;
        bus.i_read       = 1'b0;
        bus.i_addr       = '0;
        bus.i_burstcount = '0;
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        #1 rst = 1'b0;

        // 1: reset and release
        repeat (4) @(negedge clk);
        chk("rst_wait", 32'(bus.o_waitrequest), 32'(1));
        chk("rst_valid", 32'(bus.o_readdatavalid), 32'(0));
        chk("rst_data", bus.o_readdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("release_wait", 32'(bus.o_waitrequest), 32'(0));

        // 2: single burst
        for (int i = 0; i < 16; i++) load(i, 32'h100 + 32'(i));
        load(1022, 32'hDEAD03FE);
        load(1023, 32'hDEAD03FF);
        clear_got();
        issue(4, 4, t);
        bus.i_read = 1'b0;
        drain();
        chk("single_count", 32'(got_d.size()), 32'd4);
        if (got_d.size() == 4) begin
            chk("single_b0", got_d[0], 32'h104);
            chk("single_b1", got_d[1], 32'h105);
            chk("single_b2", got_d[2], 32'h106);
            chk("single_b3", got_d[3], 32'h107);
            chk("single_latency", 32'(got_c[0] - t), 32'd2);
            chk("single_contig", 32'(got_c[3] - got_c[0]), 32'd3);
        end
        chk("single_idle_busy", 32'(busy), 32'(0));

        // 3: back-to-back commands, queue fills behind a long burst
        clear_got();
        saw_wait = 1'b0;
        issue(0, 15, t);
        for (int j = 0; j < 6; j++) issue(2 * j, 2, t);
        bus.i_read = 1'b0;
        drain();
        chk("b2b_saw_wait", 32'(saw_wait), 32'(1));
        chk("b2b_count", 32'(got_d.size()), 32'd27);
        if (got_d.size() == 27) begin
            for (int i = 0; i < 15; i++) chk("b2b_long", got_d[i], 32'h100 + 32'(i));
            for (int j = 0; j < 6; j++) begin
                chk("b2b_even", got_d[15 + 2 * j], 32'h100 + 32'(2 * j));
                chk("b2b_odd", got_d[16 + 2 * j], 32'h101 + 32'(2 * j));
            end
            chk("b2b_contig", 32'(got_c[26] - got_c[0]), 32'd26);
        end

        // 4: wrap and zero burstcount
        clear_got();
        issue(1022, 4, t);
        issue(7, 0, t);
        bus.i_read = 1'b0;
        drain();
        chk("wrap_count", 32'(got_d.size()), 32'd5);
        if (got_d.size() == 5) begin
            chk("wrap_b0", got_d[0], 32'hDEAD03FE);
            chk("wrap_b1", got_d[1], 32'hDEAD03FF);
            chk("wrap_b2", got_d[2], 32'h100);
            chk("wrap_b3", got_d[3], 32'h101);
            chk("zero_b0", got_d[4], 32'h107);
        end

        // 5: load/read collision returns the old word
        load(9, 32'hAA);
        clear_got();
        issue(9, 1, t);
        bus.i_read = 1'b0;
        @(negedge clk);
        load(9, 32'hBB);
        drain();
        chk("coll_count", 32'(got_d.size()), 32'd1);
        if (got_d.size() == 1) chk("coll_old", got_d[0], 32'hAA);
        clear_got();
        issue(9, 1, t);
        bus.i_read = 1'b0;
        drain();
        chk("coll_new_count", 32'(got_d.size()), 32'd1);
        if (got_d.size() == 1) chk("coll_new", got_d[0], 32'hBB);

        // 6: reset in the middle of a burst
        clear_got();
        issue(0, 15, t);
        bus.i_read = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_valid_before", 32'(bus.o_readdatavalid), 32'(1));
        rst = 1'b0;
        #1;
        chk("mid_valid_async", 32'(bus.o_readdatavalid), 32'(0));
        chk("mid_busy_async", 32'(busy), 32'(0));
        chk("mid_wait_async", 32'(bus.o_waitrequest), 32'(1));
        repeat (3) @(negedge clk);
        clear_got();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_no_residual", 32'(got_d.size()), 32'd0);
        issue(0, 1, t);
        bus.i_read = 1'b0;
        drain();
        chk("post_count", 32'(got_d.size()), 32'd1);
        if (got_d.size() == 1) begin
            chk("post_data", got_d[0], 32'h100);
            chk("post_latency", 32'(got_c[0] - t), 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
